led_share_ctrl: RTL
===================

LED_SHARE_CTRL -- requirements
Module: led_share_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, cycles a synced button level must stay stable before acceptance (1 ms at 50 MHz).
REQ-002 Parameter HOLD_CYCLES, default 25000000, cycles local display holds the LEDs after a press preempts the CPU (0.5 s at 50 MHz).
REQ-003 Port clock  input  1  single system clock; all logic on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port button  input  4  raw push buttons, asynchronous, active-low (0 = pressed).
REQ-006 Port cpu_led  input  4  LED pattern driven by the NIOS II PIO.
REQ-007 Port cpu_req  input  1  level; CPU requests LED ownership.
REQ-008 Port cpu_gnt  output  1  registered; CPU currently owns LEDs.
REQ-009 Port btn_db  output  4  debounced buttons, active-high (1 = pressed).
REQ-010 Port btn_evt  output  4  one-cycle pulse per bit on debounced press (0->1 of btn_db).
REQ-011 Port LED  output  4  registered LED drive, active-high.

Function
REQ-012 Each button bit SHALL pass a 2-flop synchronizer, then be inverted to active-high.
REQ-013 Per bit, a debounce counter SHALL increment each cycle the synced level differs from btn_db and clear when they match.
REQ-014 When a debounce counter reaches DEBOUNCE_CYCLES-1 with the level still differing, btn_db SHALL take the synced level next cycle and the counter SHALL clear.
REQ-015 Debounce latency: btn_db SHALL change 2 (sync) + DEBOUNCE_CYCLES cycles after a stable raw change; any glitch shorter than DEBOUNCE_CYCLES SHALL leave btn_db unchanged.
REQ-016 btn_evt[i] SHALL be 1 for exactly the cycle after btn_db[i] rises; releases SHALL generate no event.
REQ-017 Ownership FSM states: LOCAL (LEDs show btn_db), CPU (LEDs show cpu_led), HOLD (LEDs show btn_db, timed).
REQ-018 LOCAL: cpu_req=1 -> CPU; else stay.
REQ-019 CPU: any btn_evt bit set -> HOLD with hold counter loaded to HOLD_CYCLES-1; else cpu_req=0 -> LOCAL; else stay.
REQ-020 CPU with btn_evt and cpu_req falling in the same cycle SHALL go to HOLD (button wins).
REQ-021 HOLD: any btn_evt SHALL reload the hold counter to HOLD_CYCLES-1; otherwise the counter SHALL decrement.
REQ-022 HOLD with counter 0 and no btn_evt: cpu_req=1 -> CPU, else -> LOCAL.
REQ-023 cpu_req changes in HOLD SHALL NOT shorten the hold.
REQ-024 cpu_gnt SHALL be 1 exactly while the FSM is in CPU, and rises the cycle after the state is entered.
REQ-025 LED SHALL register the selected source, so LED reflects the state and source one cycle after the state register updates.
REQ-026 Counter widths SHALL be $clog2 of the respective parameter (minimum 1); no counter SHALL wrap past its terminal value.

Reset
REQ-027 On reset=1 at a clock edge: state LOCAL, LED=0000, cpu_gnt=0, btn_db=0000, btn_evt=0000, all counters 0, synchronizer flops 1 (released).
REQ-028 Reset asserted mid-HOLD or mid-debounce SHALL abandon the operation with no residual event or grant after release.
REQ-029 For the first cycle after reset release, outputs SHALL hold their reset values.

Verification
All scenarios use DEBOUNCE_CYCLES=4 and HOLD_CYCLES=8.
REQ-030 button[0] held low steadily -> btn_db[0]=1 exactly 6 cycles later, one btn_evt[0] pulse, LED[0]=1 the following cycle.
REQ-031 button[1] low for 3 cycles, then high -> btn_db and btn_evt remain 0000.
REQ-032 cpu_req=1 with cpu_led=1010 in LOCAL -> cpu_gnt=1 and LED=1010 within 2 cycles; cpu_req=0 -> cpu_gnt=0 and LED=btn_db.
REQ-033 In CPU, press button[2] -> cpu_gnt=0 and LED=0100 for 8 cycles, then LED=cpu_led and cpu_gnt=1 again (cpu_req still 1).
REQ-034 In HOLD, second press at count 3 -> hold restarts at 8 cycles; btn_evt and cpu_req fall in the same cycle in CPU -> HOLD entered.
REQ-035 Reset pulse during HOLD -> next cycle LED=0000, cpu_gnt=0, state LOCAL, no btn_evt after release.

Source files
------------

// File: rtl/led_share_ctrl.sv
// LED ownership arbiter between the NIOS II PIO and four debounced local push buttons.
// A local press preempts the CPU and shows the buttons on the LEDs for a timed hold window.
module led_share_ctrl #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int HOLD_CYCLES     = 25000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] button,
    input  logic [3:0] cpu_led,
    input  logic       cpu_req,
    output logic       cpu_gnt,
    output logic [3:0] btn_db,
    output logic [3:0] btn_evt,
    output logic [3:0] LED
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HD_W-1:0] HD_LAST = HD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOCAL = 2'd0,
        ST_CPU   = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    logic [3:0]      sync_p0;
    logic [3:0]      sync_p1;
    logic [3:0]      level_p1;
    logic [DB_W-1:0] db_cnt [4];
    logic [3:0]      btn_db_p3;
    state_t          state;
    logic [HD_W-1:0] hold_cnt;

    function automatic logic [DB_W-1:0] db_inc(input logic [DB_W-1:0] c);
        return (c == DB_LAST) ? c : c + DB_W'(1);
    endfunction

    function automatic logic [HD_W-1:0] hold_dec(input logic [HD_W-1:0] c);
        return (c == '0) ? c : c - HD_W'(1);
    endfunction

    assign level_p1 = ~sync_p1;

    // Stage p0/p1: two-flop synchronizer; resets to the released (high) level
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_p0 <= 4'hF;
            sync_p1 <= 4'hF;
        end else begin
            sync_p0 <= button;
            sync_p1 <= sync_p0;
        end
    end

    // Stage p2/p3: per-bit debounce, then rising-edge event one cycle behind btn_db
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
            btn_db    <= 4'b0000;
            btn_db_p3 <= 4'b0000;
            btn_evt   <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (level_p1[i] != btn_db[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        btn_db[i] <= level_p1[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_inc(db_cnt[i]);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
            btn_db_p3 <= btn_db;
            btn_evt   <= btn_db & ~btn_db_p3;
        end
    end

    // Ownership FSM; grant and LED mux are registered from the current state
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_LOCAL;
            hold_cnt <= '0;
            cpu_gnt  <= 1'b0;
            LED      <= 4'b0000;
        end else begin
            cpu_gnt <= (state == ST_CPU);
            LED     <= (state == ST_CPU) ? cpu_led : btn_db;
            case (state)
                ST_LOCAL: begin
                    if (cpu_req) begin
                        state <= ST_CPU;
                    end
                end
                ST_CPU: begin
                    if (|btn_evt) begin
                        state    <= ST_HOLD;
                        hold_cnt <= HD_LAST;
                    end else if (!cpu_req) begin
                        state <= ST_LOCAL;
                    end
                end
                ST_HOLD: begin
                    if (|btn_evt) begin
                        hold_cnt <= HD_LAST;
                    end else if (hold_cnt == '0) begin
                        state <= cpu_req ? ST_CPU : ST_LOCAL;
                    end else begin
                        hold_cnt <= hold_dec(hold_cnt);
                    end
                end
                default: begin
                    state    <= ST_LOCAL;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

endmodule
